data_ram_arbiter: RTL and testbench
===================================

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width (sel width DATA_W/8).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports reqN_valid/reqN_ready  input/output  1  per-requester handshake, N in {0,1}.
REQ-006 The block SHALL have ports reqN_we  input  1, reqN_addr  input  ADDR_W, reqN_sel  input  DATA_W/8, reqN_wdata  input  DATA_W.
REQ-007 The block SHALL have ports rspN_valid  output  1, rspN_rdata  output  DATA_W; read response per requester.
REQ-008 The block SHALL have ports ram_ce_K, ram_we_K  output  1, ram_addr_K  output  ADDR_W, ram_sel_K  output  DATA_W/8, ram_wdata_K  output  DATA_W, ram_rdata_K  input  DATA_W, for K in {1,2}.

Function
REQ-009 Request accepted on cycle where reqN_valid && reqN_ready; accepted requests drive RAM port in same cycle (req0 -> port 1, req1 -> port 2, unless deferred).
REQ-010 Word conflict: both requests valid, addr[ADDR_W-1:2] equal, and at least one is a write.
REQ-011 No conflict: both ready high, both issued same cycle, ram_ce_K = valid, ram_we_K = we.
REQ-012 Conflict: winner issued; loser's ready low, loser's request held by requester; loser issued next cycle.
REQ-013 Winner chosen by 1-bit priority register prio (0 => req0 wins); prio flips to the loser after each conflict, unchanged otherwise.
REQ-014 FSM states IDLE and DEFER; IDLE->DEFER on conflict; DEFER->IDLE after deferred request issues; in DEFER new requests from the winner SHALL be stalled (ready low).
REQ-015 Reads: rspN_valid asserted exactly one cycle after read acceptance with rspN_rdata = matching ram_rdata_K; writes produce no response.
REQ-016 Deferred loser SHALL be issued on its own RAM port (req1 stays on port 2).
REQ-017 ram_ce_K low whenever no request is issued on port K; ram_we/sel/wdata then don't-care, but driven 0.
REQ-018 Single requester valid: always ready in IDLE; no added latency.

Reset
REQ-019 While rst_n low: state IDLE, prio 0, rspN_valid 0, rspN_rdata 0, reqN_ready 0, all ram_ce_K/ram_we_K 0.
REQ-020 Reset asserted mid-DEFER or with read in flight SHALL discard the deferred request and pending response; no response emitted after release.
REQ-021 First cycle after rst_n rises: IDLE, ready follows REQ-011/REQ-018.

Configuration
REQ-022 Macro DATA_RAM_ARB_FWD_EN, when defined: write-vs-read conflict SHALL NOT defer; both issue, read response bytes with write's sel set replaced by write data (forwarded), other bytes from RAM.
REQ-023 Without DATA_RAM_ARB_FWD_EN: every conflict per REQ-010 defers per REQ-012; write-vs-write conflicts defer in both builds.

Structure
REQ-024 Shared package SHALL hold ARB_IDLE/ARB_DEFER state encoding and the word-index helper constant (address bits [1:0] ignored).
REQ-025 One sub-module, data_ram_arb_fwd (byte-merge mux by sel), compiled only under DATA_RAM_ARB_FWD_EN.

Verification
REQ-026 req0 read 0x10, req1 read 0x20 same cycle -> both ready, rsp0/rsp1 next cycle with RAM contents.
REQ-027 Both write 0x40 (wdata 0x11111111 / 0x22222222, sel 0xF), prio 0 -> req0 first, req1 next cycle; final word 0x22222222; prio becomes 1.
REQ-028 Repeat REQ-027 conflict -> req1 now wins; final word 0x11111111; prio back to 0.
REQ-029 req0 write 0x80 data 0xAABBCCDD sel 0x3, req1 read 0x80 (old 0x12345678) -> FWD_EN: rsp1 0x1234CCDD same-latency; no FWD_EN: req1 stalled one cycle, rsp1 0x1234CCDD.
REQ-030 rst_n pulsed low while DEFER pending -> no RAM issue of deferred request, rsp valid never asserted, state IDLE.
REQ-031 req0 back-to-back reads 0x0,0x4,0x8, req1 idle -> ready constant high, three responses on consecutive cycles.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the two-requester data RAM arbiter.
// Optional feature macro used by the arbiter: DATA_RAM_ARB_FWD_EN.
package data_ram_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_DEFER = 1'b1
  } arb_state_e;

  // Word index starts here; address bits below it select a byte within the word.
  localparam int WORD_LSB = 2;

endpackage

// File: rtl/data_ram_arb_fwd.sv
// Byte-merge mux: replaces read bytes with write bytes wherever sel is set.
// Only built when DATA_RAM_ARB_FWD_EN is defined.
`ifdef DATA_RAM_ARB_FWD_EN
module data_ram_arb_fwd #(
  parameter int DATA_W = 32
) (
  input  logic                en,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   dout
);

  for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
    assign dout[b*8 +: 8] = (en && sel[b]) ? wdata[b*8 +: 8] : rdata[b*8 +: 8];
  end

endmodule
`endif

// File: rtl/data_ram_arbiter.sv
// Two-requester arbiter in front of a dual-port data RAM.
// req0 owns RAM port 1, req1 owns RAM port 2. Same-word accesses with at least
// one write are serialised: the priority winner issues now, the loser one cycle
// later on its own port. Priority toggles to the loser after every such conflict.
// Build option DATA_RAM_ARB_FWD_EN: a write-vs-read conflict issues both sides in
// the same cycle and forwards the written bytes into the read response.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W/8-1:0] req0_sel,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W/8-1:0] req1_sel,
  input  logic [DATA_W-1:0]   req1_wdata,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                ram_ce_1,
  output logic                ram_we_1,
  output logic [ADDR_W-1:0]   ram_addr_1,
  output logic [DATA_W/8-1:0] ram_sel_1,
  output logic [DATA_W-1:0]   ram_wdata_1,
  input  logic [DATA_W-1:0]   ram_rdata_1,
  output logic                ram_ce_2,
  output logic                ram_we_2,
  output logic [ADDR_W-1:0]   ram_addr_2,
  output logic [DATA_W/8-1:0] ram_sel_2,
  output logic [DATA_W-1:0]   ram_wdata_2,
  input  logic [DATA_W-1:0]   ram_rdata_2
);

  localparam int SEL_W = DATA_W/8;

  arb_state_e state;
  logic       prio;       // 0: req0 wins a conflict; in DEFER it names the owed requester
  logic [1:0] rd_vld_q;   // read issued last cycle, per requester
  logic       same_word, conflict, defer_hit, iss0, iss1;

  assign same_word = req0_addr[ADDR_W-1:WORD_LSB] == req1_addr[ADDR_W-1:WORD_LSB];
  assign conflict  = req0_valid && req1_valid && same_word && (req0_we || req1_we);

`ifdef DATA_RAM_ARB_FWD_EN
  assign defer_hit = conflict && req0_we && req1_we;
`else
  assign defer_hit = conflict;
`endif

  // Ready: both in IDLE unless a conflict stalls the loser; in DEFER only the owed side.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n) begin
      if (state == ARB_IDLE) begin
        req0_ready = !(defer_hit && prio);
        req1_ready = !(defer_hit && !prio);
      end else begin
        req0_ready = !prio;
        req1_ready = prio;
      end
    end
  end

  assign iss0 = req0_valid && req0_ready;
  assign iss1 = req1_valid && req1_ready;

  // Accepted requests go straight to their own RAM port; idle ports are driven to zero.
  assign ram_ce_1    = iss0;
  assign ram_we_1    = iss0 && req0_we;
  assign ram_addr_1  = iss0 ? req0_addr  : '0;
  assign ram_sel_1   = iss0 ? req0_sel   : '0;
  assign ram_wdata_1 = iss0 ? req0_wdata : '0;
  assign ram_ce_2    = iss1;
  assign ram_we_2    = iss1 && req1_we;
  assign ram_addr_2  = iss1 ? req1_addr  : '0;
  assign ram_sel_2   = iss1 ? req1_sel   : '0;
  assign ram_wdata_2 = iss1 ? req1_wdata : '0;

  // Arbitration FSM: a conflict enters DEFER for exactly one cycle and hands priority to the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      prio  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: if (defer_hit) begin
          state <= ARB_DEFER;
          prio  <= ~prio;
        end
        ARB_DEFER: state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

  // Read responses appear the cycle after issue, when the RAM data is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_q <= '0;
    else        rd_vld_q <= {iss1 && !req1_we, iss0 && !req0_we};
  end

  assign rsp0_valid = rd_vld_q[0];
  assign rsp1_valid = rd_vld_q[1];

`ifdef DATA_RAM_ARB_FWD_EN
  logic              fwd0_q, fwd1_q;
  logic [SEL_W-1:0]  fwd_sel_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] merged0, merged1;
  logic              fwd_hit;

  // Same-cycle write and read of one word: only the write side's bytes need forwarding.
  assign fwd_hit = (state == ARB_IDLE) && conflict && !defer_hit;

  // Capture the write bytes that the read side must see in place of the stale RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd0_q     <= 1'b0;
      fwd1_q     <= 1'b0;
      fwd_sel_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd0_q     <= fwd_hit && !req0_we;
      fwd1_q     <= fwd_hit && !req1_we;
      fwd_sel_q  <= req0_we ? req0_sel   : req1_sel;
      fwd_data_q <= req0_we ? req0_wdata : req1_wdata;
    end
  end

  data_ram_arb_fwd #(.DATA_W(DATA_W)) u_fwd0 (
    .en(fwd0_q), .sel(fwd_sel_q), .wdata(fwd_data_q), .rdata(ram_rdata_1), .dout(merged0)
  );
  data_ram_arb_fwd #(.DATA_W(DATA_W)) u_fwd1 (
    .en(fwd1_q), .sel(fwd_sel_q), .wdata(fwd_data_q), .rdata(ram_rdata_2), .dout(merged1)
  );

  assign rsp0_rdata = rd_vld_q[0] ? merged0 : '0;
  assign rsp1_rdata = rd_vld_q[1] ? merged1 : '0;
`else
  assign rsp0_rdata = rd_vld_q[0] ? ram_rdata_1 : '0;
  assign rsp1_rdata = rd_vld_q[1] ? ram_rdata_2 : '0;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level model (memory array + arbitration rules).
module tb_data_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
`ifdef DATA_RAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [SW-1:0] req0_sel;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [SW-1:0] req1_sel;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          ram_ce_1, ram_we_1, ram_ce_2, ram_we_2;
  logic [AW-1:0] ram_addr_1, ram_addr_2;
  logic [SW-1:0] ram_sel_1, ram_sel_2;
  logic [DW-1:0] ram_wdata_1, ram_wdata_2, ram_rdata_1, ram_rdata_2;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_sel(req0_sel), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_sel(req1_sel), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_ce_1(ram_ce_1), .ram_we_1(ram_we_1), .ram_addr_1(ram_addr_1),
    .ram_sel_1(ram_sel_1), .ram_wdata_1(ram_wdata_1), .ram_rdata_1(ram_rdata_1),
    .ram_ce_2(ram_ce_2), .ram_we_2(ram_we_2), .ram_addr_2(ram_addr_2),
    .ram_sel_2(ram_sel_2), .ram_wdata_2(ram_wdata_2), .ram_rdata_2(ram_rdata_2)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Dual-port synchronous RAM, read-before-write, byte enables.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_ce_1) begin
      ram_rdata_1 <= mem[ram_addr_1[7:2]];
      if (ram_we_1) mem[ram_addr_1[7:2]] <= merge(mem[ram_addr_1[7:2]], ram_wdata_1, ram_sel_1);
    end
    if (ram_ce_2) begin
      ram_rdata_2 <= mem[ram_addr_2[7:2]];
      if (ram_we_2) mem[ram_addr_2[7:2]] <= merge(mem[ram_addr_2[7:2]], ram_wdata_2, ram_sel_2);
    end
  end

  // Reference model: memory contents as seen by correctly serialised traffic,
  // plus the arbitration bookkeeping (priority owner and who is owed a slot).
  logic [31:0] mmem [0:63];
  bit          m_prio, m_defer, m_owed;
  bit          acc0, acc1;
  logic [31:0] last_rsp1;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: called at a negedge with inputs already applied.
  task automatic cyc();
    bit          e0, e1, conf, ev0, ev1;
    logic [31:0] ed0, ed1;
    conf = req0_valid && req1_valid && (req0_addr[AW-1:2] == req1_addr[AW-1:2]) &&
           (req0_we || req1_we) && !(FWD && (req0_we != req1_we));
    if (m_defer)   begin e0 = (m_owed == 1'b0); e1 = (m_owed == 1'b1); end
    else if (conf) begin e0 = !m_prio;          e1 = m_prio;           end
    else           begin e0 = 1'b1;             e1 = 1'b1;             end
    #1;
    chk("rdy0", 32'(req0_ready), 32'(e0));
    chk("rdy1", 32'(req1_ready), 32'(e1));
    acc0 = req0_valid && e0;
    acc1 = req1_valid && e1;
    chk("ce1", 32'(ram_ce_1), 32'(acc0));
    chk("ce2", 32'(ram_ce_2), 32'(acc1));
    if (acc0) chk("addr1", ram_addr_1, req0_addr);
    if (acc1) chk("addr2", ram_addr_2, req1_addr);
    @(posedge clk);
    // Reads observe every write issued in the same cycle (serialised order).
    if (acc0 && req0_we) mmem[req0_addr[7:2]] = merge(mmem[req0_addr[7:2]], req0_wdata, req0_sel);
    if (acc1 && req1_we) mmem[req1_addr[7:2]] = merge(mmem[req1_addr[7:2]], req1_wdata, req1_sel);
    ev0 = acc0 && !req0_we;  ed0 = mmem[req0_addr[7:2]];
    ev1 = acc1 && !req1_we;  ed1 = mmem[req1_addr[7:2]];
    if (m_defer) m_defer = 1'b0;
    else if (conf) begin
      m_defer = 1'b1;
      m_owed  = !m_prio;
      m_prio  = m_owed;
    end
    @(negedge clk);
    chk("rspv0", 32'(rsp0_valid), 32'(ev0));
    chk("rspv1", 32'(rsp1_valid), 32'(ev1));
    if (ev0) chk("rsp0", rsp0_rdata, ed0);
    if (ev1) chk("rsp1", rsp1_rdata, ed1);
    if (rsp1_valid) last_rsp1 = rsp1_rdata;
  endtask

  task automatic drv(input int n, input bit v, input bit we, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    if (n == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_sel = s; req0_wdata = d; end
    else        begin req1_valid = v; req1_we = we; req1_addr = a; req1_sel = s; req1_wdata = d; end
  endtask

  task automatic rnd(input int n);
    logic [31:0] a;
    a = 32'(($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
    drv(n, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
  endtask

  // Run until both requesters have been accepted, bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((req0_valid || req1_valid) && n < 4) begin
      cyc();
      n++;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    chk("drain", 32'(req0_valid || req1_valid), 32'd0);
  endtask

  // Assert reset at a negedge with requests still presented; outputs must be quiet.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_rspv0", 32'(rsp0_valid), 32'd0);
    chk("rst_rspv1", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0", rsp0_rdata, 32'd0);
    chk("rst_rsp1", rsp1_rdata, 32'd0);
    chk("rst_ce1", 32'(ram_ce_1), 32'd0);
    chk("rst_ce2", 32'(ram_ce_2), 32'd0);
    chk("rst_we", 32'({ram_we_1, ram_we_2}), 32'd0);
    repeat (2) @(negedge clk);
    m_defer = 1'b0;
    m_prio  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    drv(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; mmem[i] = mem[i]; end
    mem[32] = 32'h12345678; mmem[32] = 32'h12345678;
    m_prio = 1'b0; m_defer = 1'b0; m_owed = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0; last_rsp1 = '0;
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
    drv(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'd1);
    reset_pulse();

    // Reset while a conflict is deferred and a read response is in flight.
    drv(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'd0);
    drv(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h5A5A5A5A);
    cyc();
    reset_pulse();
    repeat (3) cyc();
    chk("r030_mem", mem[16], mmem[16]);

    // Two reads, different words: both served in one cycle.
    drv(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
    drv(1, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0);
    drain();

    // Write/write conflict twice: winner alternates.
    drv(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h11111111);
    drv(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h22222222);
    drain();
    chk("w027", mem[16], 32'h22222222);
    drv(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h11111111);
    drv(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h22222222);
    drain();
    chk("w028", mem[16], 32'h11111111);

    // Partial write vs read of the same word.
    drv(0, 1'b1, 1'b1, 32'h80, 4'h3, 32'hAABBCCDD);
    drv(1, 1'b1, 1'b0, 32'h80, 4'hF, 32'd0);
    last_rsp1 = '0;
    drain();
    chk("r029", last_rsp1, 32'h1234CCDD);

    // Back-to-back reads from one requester.
    drv(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'd0); cyc();
    drv(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'd0); cyc();
    drv(0, 1'b1, 1'b0, 32'h8, 4'hF, 32'd0); cyc();
    req0_valid = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;

    // Random traffic; requests are held until accepted.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse();
      if (!req0_valid || acc0) rnd(0);
      if (!req1_valid || acc1) rnd(1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
